// File: rtl/div32x32.sv
// Sequential 32-bit unsigned restoring divider, one quotient bit per clock.
// Shares the start/busy/done handshake of the 32x32 multiplier.
module div32x32 (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_by_zero
);

    typedef enum logic {IDLE, CALC} state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] q_w;
    logic [31:0] r_w;
    logic [31:0] d;
    logic [4:0]  cnt;
    logic [32:0] trial;
    logic [32:0] diff;
    logic [31:0] q_next;
    logic [31:0] r_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start && (b != 32'd0)) state_next = CALC;
            CALC: if (cnt == 5'd31) state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == CALC);
    end

    // The trial is 33 bits wide because a remainder >= 2^31 overflows 32 bits
    // once shifted; bit 32 of the difference is the borrow.
    always_comb begin
        trial = {r_w, q_w[31]};
        diff  = trial - {1'b0, d};
        if (!diff[32]) begin
            r_next = diff[31:0];
            q_next = {q_w[30:0], 1'b1};
        end else begin
            r_next = trial[31:0];
            q_next = {q_w[30:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_w         <= 32'd0;
            r_w         <= 32'd0;
            d           <= 32'd0;
            cnt         <= 5'd0;
            done        <= 1'b0;
            quotient    <= 32'd0;
            remainder   <= 32'd0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (b != 32'd0) begin
                            q_w         <= a;
                            d           <= b;
                            r_w         <= 32'd0;
                            cnt         <= 5'd0;
                            div_by_zero <= 1'b0;
                        end else begin
                            // Divide by zero resolves in a single edge without iterating.
                            quotient    <= 32'hFFFF_FFFF;
                            remainder   <= a;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    q_w <= q_next;
                    r_w <= r_next;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        quotient  <= q_next;
                        remainder <= r_next;
                        done      <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div32x32.sv
// Self-checking bench for div32x32: directed cases plus a short random
// regression, with expected results queued at start and popped at done.
module tb_div32x32;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_q = 32'd0;

    div32x32 dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Called at a negedge: drives a request and queues its reference result.
    task automatic apply_stimulus(input logic [31:0] av, input logic [31:0] bv);
        exp_t e;
        e.a = av;
        e.b = bv;
        if (bv == 32'd0) begin
            e.q   = 32'hFFFF_FFFF;
            e.r   = av;
            e.dbz = 1'b1;
        end else begin
            e.q   = av / bv;
            e.r   = av % bv;
            e.dbz = 1'b0;
        end
        sb.push_back(e);
        a     = av;
        b     = bv;
        start = 1'b1;
    endtask

    // Returns at the negedge where done is seen; glitch>0 injects an extra start pulse.
    task automatic wait_done(input int glitch, output int cycles, output int busy_cycles);
        bit seen;
        cycles      = 0;
        busy_cycles = 0;
        seen        = 0;
        while (!seen) begin
            @(negedge clk);
            cycles++;
            if (cycles == 1) begin
                start = 1'b0;
                a     = $urandom;
                b     = $urandom;
            end
            if (glitch > 0 && cycles == glitch) begin
                start = 1'b1;
                a     = 32'd1;
                b     = 32'd1;
            end else if (glitch > 0 && cycles == glitch + 1) begin
                start = 1'b0;
            end
            if (cycles == 16) check("hold_quotient", {32'd0, quotient}, {32'd0, last_q});
            if (busy) busy_cycles++;
            if (done) seen = 1;
            else if (cycles >= 100) begin
                check("done_timeout", 64'd0, 64'd1);
                seen = 1;
            end
        end
    endtask

    task automatic check_output();
        exp_t        e;
        logic [63:0] recon;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            check("quotient", {32'd0, quotient}, {32'd0, e.q});
            check("remainder", {32'd0, remainder}, {32'd0, e.r});
            check("div_by_zero", {63'd0, div_by_zero}, {63'd0, e.dbz});
            if (!e.dbz) begin
                recon = 64'(quotient) * 64'(e.b) + 64'(remainder);
                check("invariant_recon", recon, 64'(e.a));
                check("invariant_rem_lt_b", {63'd0, (remainder < e.b)}, 64'd1);
            end
            last_q = e.q;
        end
    endtask

    task automatic run_op(input logic [31:0] av, input logic [31:0] bv);
        int cyc;
        int bc;
        apply_stimulus(av, bv);
        wait_done(0, cyc, bc);
        check("latency", 64'(cyc), (bv == 32'd0) ? 64'd1 : 64'd33);
        check("busy_cycles", 64'(bc), (bv == 32'd0) ? 64'd0 : 64'd32);
        check("busy_in_done", {63'd0, busy}, 64'd0);
        check_output();
        @(negedge clk);
        check("done_single_cycle", {63'd0, done}, 64'd0);
    endtask

    initial begin
        int   cyc;
        int   bc;
        exp_t dropped;
        logic [31:0] ra;
        logic [31:0] rb;

        reset = 1'b1;
        start = 1'b0;
        a     = 32'd0;
        b     = 32'd0;
        repeat (2) @(negedge clk);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_quotient", {32'd0, quotient}, 64'd0);
        check("reset_remainder", {32'd0, remainder}, 64'd0);
        check("reset_dbz", {63'd0, div_by_zero}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] directed cases");
        run_op(32'd100, 32'd7);
        run_op(32'hFFFF_FFFF, 32'd1);
        run_op(32'hFFFF_FFFF, 32'h8000_0000);
        run_op(32'd3, 32'd10);
        run_op(32'd10, 32'd10);
        run_op(32'd5, 32'd0);
        run_op(32'd9, 32'd4);

        $display("[TB] ignored start and back-to-back");
        apply_stimulus(32'd100, 32'd7);
        wait_done(10, cyc, bc);
        check("glitch_latency", 64'(cyc), 64'd33);
        check_output();
        apply_stimulus(32'd50, 32'd3);
        wait_done(0, cyc, bc);
        check("b2b_latency", 64'(cyc), 64'd33);
        check_output();
        @(negedge clk);

        $display("[TB] reset mid-operation");
        apply_stimulus(32'd100, 32'd7);
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_quotient", {32'd0, quotient}, 64'd0);
        check("abort_remainder", {32'd0, remainder}, 64'd0);
        check("abort_dbz", {63'd0, div_by_zero}, 64'd0);
        dropped = sb.pop_back();
        last_q  = 32'd0;
        @(negedge clk);
        check("abort_no_done", {63'd0, done}, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        run_op(32'd20, 32'd6);

        $display("[TB] random regression");
        for (int i = 0; i < 200; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'($urandom_range(1, 255));
                1: rb = $urandom | 32'h8000_0000;
                2: rb = (i % 20 == 0) ? 32'd0 : $urandom;
                default: rb = $urandom >> $urandom_range(0, 31);
            endcase
            run_op(ra, rb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
